fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of the main decoder. Owns the PC.
//  Issues in-order requests to instruction memory (variable latency, valid/ready).
//  Buffers up to 2 responses and presents {instr, pc, pc+4} to decode through a valid/ready handshake.
//  Accepts redirects from execute (branch/JAL/JALR) and discards wrong-path fetches.
// PARAMETERS
//  XLEN      32     address/instruction width
//  RESET_PC  32'h0  PC loaded on reset (word aligned)
//  DEPTH     2      max (in-flight requests + buffered instrs); fixed 2
// PORTS
//  clk_i            in   1     clock, rising edge
//  rst_i            in   1     synchronous reset, active-high
//  imem_req_valid   out  1     request to instruction memory
//  imem_req_ready   in   1     memory accepts request this cycle
//  imem_req_addr    out  XLEN  fetch address (= pc_q)
//  imem_rsp_valid   in   1     response data valid (in order, >=1 cycle after accept)
//  imem_rsp_data    in   XLEN  fetched instruction word
//  redirect_en_i    in   1     taken branch/jump from execute
//  redirect_pc_i    in   XLEN  new PC; bits [1:0] ignored (forced 0)
//  if_valid         out  1     instruction available to decode
//  if_ready_i       in   1     decode consumes instruction this cycle
//  if_instr         out  XLEN  instruction (opcode = if_instr[6:0] to decoder)
//  if_pc            out  XLEN  PC of if_instr
//  if_pc_plus4      out  XLEN  if_pc + 4 (link value for JAL/JALR writeback)
// BEHAVIOUR
//  Reset: pc_q=RESET_PC; buffer empty; inflight=0; discard=0; imem_req_valid=0,
//   if_valid=0, if_instr/if_pc/if_pc_plus4=0 during reset cycle.
//  Issue: imem_req_valid = !rst_i && (inflight + count < 2). Accept = valid&&ready
//   -> pc_q += 4 (mod 2^XLEN, wraps 0xFFFFFFFC->0), inflight+1, addr pushed to PC queue.
//  Response: rsp_valid with discard>0 -> dropped, discard-1, inflight-1.
//   Else pushed into 2-entry buffer with its PC, inflight-1. Credit rule guarantees no overflow.
//   rsp_valid with inflight==0 is a protocol error: ignored, no state change.
//  Output: if_valid = count>0; if_* driven from buffer head (registered, not from rsp bus).
//   Pop on if_valid && if_ready_i. Push and pop same cycle: count unchanged, order kept.
//   Best case: req accept at T, rsp at T+1, if_valid at T+2.
//  Redirect (redirect_en_i=1), highest priority, same cycle:
//   pc_q <= {redirect_pc_i[XLEN-1:2],2'b00}; buffer flushed (count=0, pop ignored);
//   discard <= inflight_next (all in-flight incl. any accepted this cycle and
//   excluding a response arriving this cycle, which is itself dropped).
//   if_valid=0 next cycle; first fetch of new path may issue the cycle after redirect.
//  Back-to-back redirects: last one wins; discard recomputed each time.
//  Counters: inflight, discard 2 bits, never exceed 2; discard <= inflight always.
//  Stall: if_ready_i=0 with count=2 -> imem_req_valid=0, pc_q held.
//  Reset mid-operation overrides everything; later responses for pre-reset requests
//   are ignored by the inflight==0 rule (memory reset together with core).
// TESTING
//  1. Reset, ready=1, 1-cycle mem, if_ready=1 -> if_pc 0,4,8,12 one per cycle;
//     if_pc_plus4=if_pc+4; first if_valid 2 cycles after rst_i drops.
//  2. if_ready_i=0 for 10 cycles -> exactly 2 requests issued (0x0,0x4), if_pc held
//     at 0x0, imem_req_valid=0 until pop; no instruction lost or duplicated.
//  3. Redirect to 0x103 with 2 in flight -> both responses dropped, next if_pc=0x100,
//     then 0x104; no wrong-path if_valid.
//  4. Redirect in same cycle as rsp_valid and req accept -> rsp dropped, accepted
//     req discarded, only 0x100-path instrs reach decode.
//  5. RESET_PC=32'hFFFF_FFF8 -> if_pc FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
//  6. Random mem latency 1-5 + random ready/redirect vs golden PC model -> if_pc
//     sequence matches; inflight+count never >2; rst_i mid-burst -> if_pc restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing in-order imem requests, buffering up to 2 instructions for decode, squashing wrong-path fetches on redirect
module fetch_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_en_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            if_valid,
  input  logic            if_ready_i,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4
);
  logic [XLEN-1:0] r_pc;
  logic [1:0]      r_inflight, r_discard, r_count;
  logic [XLEN-1:0] r_instr [2];
  logic [XLEN-1:0] r_ipc [2];
  logic            w_acc, w_rsp, w_drop, w_push, w_pop, w_slot;
  logic [1:0]      w_inflight_nx;
  logic [2:0]      w_used;
  logic [XLEN-1:0] w_rsp_pc;
  always_comb begin
    w_used         = {1'b0, r_inflight} + {1'b0, r_count};
    imem_req_valid = !rst_i && (w_used < 3'(DEPTH));
    w_acc          = imem_req_valid && imem_req_ready;
    w_rsp          = imem_rsp_valid && (r_inflight != 2'd0);
    w_drop         = w_rsp && (r_discard != 2'd0);
    w_push         = w_rsp && !w_drop && !redirect_en_i;
    w_pop          = (r_count != 2'd0) && if_ready_i;
    w_inflight_nx  = r_inflight + {1'b0, w_acc} - {1'b0, w_rsp};
    w_slot         = r_count[1] || (r_count[0] && !w_pop);
    // surviving in-flight requests are sequential and end just below r_pc
    w_rsp_pc       = r_pc - {{(XLEN-4){1'b0}}, r_inflight - r_discard, 2'b00};
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc       <= RESET_PC;
      r_inflight <= '0;
      r_discard  <= '0;
      r_count    <= '0;
      r_instr[0] <= '0;
      r_instr[1] <= '0;
      r_ipc[0]   <= '0;
      r_ipc[1]   <= '0;
    end else begin
      r_inflight <= w_inflight_nx;
      if (redirect_en_i) begin
        r_pc      <= redirect_pc_i & ~XLEN'(3);
        r_discard <= w_inflight_nx;
        r_count   <= '0;
      end else begin
        if (w_acc) r_pc <= r_pc + XLEN'(4);
        if (w_drop) r_discard <= r_discard - 2'd1;
        r_count <= r_count - {1'b0, w_pop} + {1'b0, w_push};
        if (w_pop) begin
          r_instr[0] <= r_instr[1];
          r_ipc[0]   <= r_ipc[1];
        end
        if (w_push) begin
          r_instr[w_slot] <= imem_rsp_data;
          r_ipc[w_slot]   <= w_rsp_pc;
        end
      end
    end
  end
  assign imem_req_addr = r_pc;
  assign if_valid      = !rst_i && (r_count != 2'd0);
  assign if_instr      = rst_i ? '0 : r_instr[0];
  assign if_pc         = rst_i ? '0 : r_ipc[0];
  assign if_pc_plus4   = rst_i ? '0 : r_ipc[0] + XLEN'(4);
endmodule
